// File: rtl/hazard_stall_unit.sv
// Stall/bubble controller for the 5-stage rv32i pipeline: load-use, I-cache and D-cache waits.
// Also tracks a sticky D-cache timeout and saturating stall/load-use counters.
module hazard_stall_unit #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ID_rs1_num,
    input  logic [4:0]           ID_rs2_num,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic [4:0]           EX_rd_num,
    input  logic                 EX_load_regfile,
    input  logic                 EX_mem_read,
    input  logic                 MEM_mem_req,
    input  logic                 dmem_resp,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    output logic                 stall_IF,
    output logic                 stall_ID,
    output logic                 stall_EX,
    output logic                 stall_MEM,
    output logic                 bubble_EX,
    output logic                 bubble_WB,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] load_use_events
);

    typedef enum logic [0:0] {StRun, StDwait} state_e;

    state_e state_q, state_d;

    logic lu;
    logic dwait;
    logic iwait;
    logic lu_active;

    logic [CNT_WIDTH-1:0] stall_cycles_q;
    logic [CNT_WIDTH-1:0] load_use_events_q;

    always_comb begin
        lu = EX_mem_read && EX_load_regfile && (EX_rd_num != 5'd0)
             && ((ID_uses_rs1 && (ID_rs1_num == EX_rd_num))
              || (ID_uses_rs2 && (ID_rs2_num == EX_rd_num)));
        dwait = MEM_mem_req && !dmem_resp;
        iwait = imem_read && !imem_resp;
    end

    // Outputs follow the live dwait term in both states so release lands in the resp cycle.
    always_comb begin
        state_d   = state_q;
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        stall_EX  = 1'b0;
        stall_MEM = 1'b0;
        bubble_EX = 1'b0;
        bubble_WB = 1'b0;
        lu_active = 1'b0;

        unique case (state_q)
            StRun:   if (dwait)  state_d = StDwait;
            StDwait: if (!dwait) state_d = StRun;
            default: state_d = StRun;
        endcase

        if (!rst) begin
            if (dwait) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                stall_EX  = 1'b1;
                stall_MEM = 1'b1;
                bubble_WB = 1'b1;
            end else if (lu) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                bubble_EX = 1'b1;
                lu_active = 1'b1;
            end else if (iwait) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                bubble_EX = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StRun;
            stall_cycles_q    <= '0;
            load_use_events_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_IF && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
            end
            if (lu_active && (load_use_events_q != '1)) begin
                load_use_events_q <= load_use_events_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign load_use_events = load_use_events_q;

    if (TIMEOUT > 0) begin : g_timeout
        localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

        logic [TW-1:0] wait_cnt_q;
        logic          timeout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                wait_cnt_q <= '0;
                timeout_q  <= 1'b0;
            end else begin
                if (state_q == StRun) begin
                    wait_cnt_q <= '0;
                end else if (wait_cnt_q != TLast) begin
                    wait_cnt_q <= wait_cnt_q + TW'(1);
                end
                if ((state_q == StDwait) && dwait && (wait_cnt_q == TLast)) begin
                    timeout_q <= 1'b1;
                end
            end
        end

        assign mem_timeout = timeout_q;
    end else begin : g_no_timeout
        assign mem_timeout = 1'b0;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a second instance with CNT_WIDTH=4 checks saturation.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1_num, ID_rs2_num, EX_rd_num;
    logic       ID_uses_rs1, ID_uses_rs2, EX_load_regfile, EX_mem_read;
    logic       MEM_mem_req, dmem_resp, imem_read, imem_resp;

    logic        stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_WB, mem_timeout;
    logic [31:0] stall_cycles, load_use_events;
    logic        s4_if, s4_id, s4_ex, s4_mem, b4_ex, b4_wb, to4;
    logic [3:0]  stall_cycles4, load_use_events4;

    logic [5:0] outs;
    assign outs = {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_WB};

    localparam logic [5:0] ONone  = 6'b000000;
    localparam logic [5:0] OBub   = 6'b110010;  // lu or iwait
    localparam logic [5:0] OFreeze = 6'b111101;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1_num(ID_rs1_num), .ID_rs2_num(ID_rs2_num),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd_num(EX_rd_num), .EX_load_regfile(EX_load_regfile), .EX_mem_read(EX_mem_read),
        .MEM_mem_req(MEM_mem_req), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
        .bubble_EX(bubble_EX), .bubble_WB(bubble_WB), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .load_use_events(load_use_events)
    );

    hazard_stall_unit #(.CNT_WIDTH(4), .TIMEOUT(0)) dut4 (
        .clk(clk), .rst(rst),
        .ID_rs1_num(ID_rs1_num), .ID_rs2_num(ID_rs2_num),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd_num(EX_rd_num), .EX_load_regfile(EX_load_regfile), .EX_mem_read(EX_mem_read),
        .MEM_mem_req(MEM_mem_req), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .stall_IF(s4_if), .stall_ID(s4_id), .stall_EX(s4_ex), .stall_MEM(s4_mem),
        .bubble_EX(b4_ex), .bubble_WB(b4_wb), .mem_timeout(to4),
        .stall_cycles(stall_cycles4), .load_use_events(load_use_events4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        ID_rs1_num = 0; ID_rs2_num = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        EX_rd_num = 0; EX_load_regfile = 0; EX_mem_read = 0;
        MEM_mem_req = 0; dmem_resp = 0; imem_read = 0; imem_resp = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        EX_rd_num = rd; EX_load_regfile = 1; EX_mem_read = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        step(1);
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        MEM_mem_req = 1;
        imem_read = 1;
        step(2);
        check_eq("rst_outs_forced", 32'(outs), 32'(ONone));
        check_eq("rst_stall_cnt", stall_cycles, 0);
        check_eq("rst_timeout", 32'(mem_timeout), 0);
        clear_inputs();
        rst = 0;
        #1;

        // 1. load-use on rs1
        set_load(5); ID_uses_rs1 = 1; ID_rs1_num = 5;
        #1 check_eq("lu_outs", 32'(outs), 32'(OBub));
        step(1);
        check_eq("lu_events", load_use_events, 1);
        EX_mem_read = 0; EX_load_regfile = 0; EX_rd_num = 0;
        #1 check_eq("lu_after_bubble", 32'(outs), 32'(ONone));
        step(1);
        check_eq("lu_events_hold", load_use_events, 1);
        check_eq("lu_stall_cycles", stall_cycles, 1);

        // 2. non-hazards
        set_load(0); ID_uses_rs1 = 1; ID_rs1_num = 0;
        #1 check_eq("rd_x0", 32'(outs), 32'(ONone));
        set_load(5); ID_rs1_num = 3; ID_uses_rs2 = 0; ID_rs2_num = 5;
        #1 check_eq("op_imm_rs2", 32'(outs), 32'(ONone));
        ID_uses_rs2 = 1;
        #1 check_eq("rs2_hazard", 32'(outs), 32'(OBub));
        EX_load_regfile = 0;
        #1 check_eq("no_load_regfile", 32'(outs), 32'(ONone));
        step(1);
        check_eq("non_hazard_events", load_use_events, 1);
        clear_inputs();

        // 3. D-cache wait for 4 cycles, resp in the 5th
        do_reset();
        MEM_mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("dwait_c%0d", i), 32'(outs), 32'(OFreeze));
            step(1);
        end
        dmem_resp = 1;
        #1 check_eq("dwait_release", 32'(outs), 32'(ONone));
        step(1);
        check_eq("dwait_stall_cnt", stall_cycles, 4);
        check_eq("dwait_no_timeout", 32'(mem_timeout), 0);
        clear_inputs();

        // 4. dwait overlapping lu
        do_reset();
        MEM_mem_req = 1; set_load(7); ID_uses_rs2 = 1; ID_rs2_num = 7;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("dwlu_c%0d", i), 32'(outs), 32'(OFreeze));
            step(1);
        end
        check_eq("dwlu_no_events", load_use_events, 0);
        dmem_resp = 1;
        #1 check_eq("dwlu_resp_lu", 32'(outs), 32'(OBub));
        step(1);
        check_eq("dwlu_events", load_use_events, 1);
        check_eq("dwlu_stall_cnt", stall_cycles, 4);
        clear_inputs();

        // 5. timeout with TIMEOUT=8
        do_reset();
        MEM_mem_req = 1;
        step(6);
        check_eq("timeout_early", 32'(mem_timeout), 0);
        step(3);
        check_eq("timeout_set", 32'(mem_timeout), 1);
        dmem_resp = 1;
        step(1);
        clear_inputs();
        step(1);
        check_eq("timeout_sticky", 32'(mem_timeout), 1);
        check_eq("timeout_released", 32'(outs), 32'(ONone));
        do_reset();
        check_eq("timeout_cleared", 32'(mem_timeout), 0);

        // 6. reset mid-DWAIT and mid-iwait
        MEM_mem_req = 1;
        step(2);
        rst = 1;
        #1 check_eq("rst_mid_dwait", 32'(outs), 32'(ONone));
        step(1);
        rst = 0; MEM_mem_req = 0;
        #1 check_eq("post_rst_stall_cnt", stall_cycles, 0);
        imem_read = 1;
        #1 check_eq("iwait_outs", 32'(outs), 32'(OBub));
        imem_resp = 1;
        #1 check_eq("iwait_resp", 32'(outs), 32'(ONone));
        imem_resp = 0;
        rst = 1;
        #1 check_eq("rst_mid_iwait", 32'(outs), 32'(ONone));
        step(1);
        rst = 0;
        check_eq("post_rst_events", load_use_events, 0);
        check_eq("post_rst_stall_cnt2", stall_cycles, 0);

        // saturation of the 4-bit counter over 20 stall cycles
        step(20);
        check_eq("sat_cnt4", 32'(stall_cycles4), 15);
        check_eq("cnt32_20", stall_cycles, 20);
        clear_inputs();
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
